// File: rtl/bcd_press_counter_pkg.sv
// Shared widths, BCD digit limits and debounce FSM encoding for the press counter.
package bcd_press_counter_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned BCD_W       = BCD_DIGIT_W * NUM_DIGITS;
    localparam int unsigned DEB_CNT_W   = 20;

    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } btn_state_e;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the up/down counter; ripples carry (up) or borrow (down) to the next digit.
module bcd_digit_step
    import bcd_press_counter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    input  logic                   up,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] digit_next,
    output logic                   cout
);

    always_comb begin
        digit_next = digit;
        cout       = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    digit_next = '0;
                    cout       = 1'b1;
                end else begin
                    digit_next = digit + BCD_DIGIT_W'(1);
                end
            end else begin
                if (digit == '0) begin
                    digit_next = BCD_MAX;
                    cout       = 1'b1;
                end else begin
                    digit_next = digit - BCD_DIGIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_press_counter.sv
// Synchronizes and debounces an active-low button, then counts accepted presses
// up or down as a 4-digit packed BCD value with one-cycle step/wrap pulses.
module bcd_press_counter
    import bcd_press_counter_pkg::*;
#(
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter logic [BCD_W-1:0] RESET_VALUE     = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_n,
    input  logic             up,
    input  logic             clr,
    output logic [BCD_W-1:0] count_bcd,
    output logic             step,
    output logic             wrap,
    output logic             pressed
);

    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]           sync_q;
    logic                 btn_s;
    logic [DEB_CNT_W-1:0] deb_cnt_q;
    logic [DEB_CNT_W-1:0] deb_cnt_d;
    btn_state_e           state_q;
    logic                 pressed_q;
    logic [BCD_W-1:0]     count_q;
    logic [BCD_W-1:0]     count_d;
    logic                 step_q;
    logic                 wrap_q;
    logic                 level_differs;
    logic                 accept;
    logic                 press_accept;
    logic [NUM_DIGITS:0]  carry;

    assign btn_s = sync_q[1];

    // Accepted level is "released" (btn_s = 1) in RELEASED and "held" (btn_s = 0) in HELD.
    assign level_differs = (state_q == RELEASED) ? ~btn_s : btn_s;
    assign accept        = level_differs && (deb_cnt_q == DEB_LAST);
    assign press_accept  = accept && (state_q == RELEASED);

    always_comb begin
        deb_cnt_d = deb_cnt_q + DEB_CNT_W'(1);
        if (!level_differs || accept) begin
            deb_cnt_d = '0;
        end
    end

    assign carry[0] = press_accept;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_step u_digit (
            .digit      (count_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .up         (up),
            .cin        (carry[g]),
            .digit_next (count_d[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout       (carry[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            deb_cnt_q <= '0;
            state_q   <= RELEASED;
            pressed_q <= 1'b0;
            count_q   <= RESET_VALUE;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_n};
            deb_cnt_q <= deb_cnt_d;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;

            if (accept) begin
                case (state_q)
                    RELEASED: begin
                        state_q   <= HELD;
                        pressed_q <= 1'b1;
                    end
                    HELD: begin
                        state_q   <= RELEASED;
                        pressed_q <= 1'b0;
                    end
                endcase
            end

            // Clear wins over a coincident press but leaves the debouncer alone.
            if (clr) begin
                count_q <= RESET_VALUE;
            end else if (press_accept) begin
                count_q <= count_d;
                step_q  <= 1'b1;
                wrap_q  <= carry[NUM_DIGITS];
            end
        end
    end

    assign count_bcd = count_q;
    assign step      = step_q;
    assign wrap      = wrap_q;
    assign pressed   = pressed_q;

endmodule

// File: tb/tb_bcd_press_counter.sv
// Randomized press/bounce stimulus with an integer reference model; a negedge
// monitor pops expected step results from a queue and compares them.
module tb_bcd_press_counter;

    localparam int unsigned DEB     = 4;
    localparam logic [15:0] RST_VAL = 16'h9998;
    localparam int          RST_INT = 9998;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_n = 1'b1;
    logic        up = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] count_bcd;
    logic        step;
    logic        wrap;
    logic        pressed;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int step_cyc = -1;
    int model_val = RST_INT;
    logic prev_step = 1'b0;

    typedef struct {
        logic [15:0] cnt;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];

    bcd_press_counter #(
        .DEBOUNCE_CYCLES (DEB),
        .RESET_VALUE     (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .up        (up),
        .clr       (clr),
        .count_bcd (count_bcd),
        .step      (step),
        .wrap      (wrap),
        .pressed   (pressed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Decimal reference: value is a plain integer modulo 10000.
    function automatic void model_press(input logic dir);
        int   nv;
        logic w;
        if (dir) begin
            w  = (model_val == 9999);
            nv = (model_val + 1) % 10000;
        end else begin
            w  = (model_val == 0);
            nv = (model_val + 9999) % 10000;
        end
        model_val = nv;
        exp_q.push_back('{cnt: to_bcd(nv), wr: w});
    endfunction

    always @(negedge clk) begin
        if (wrap === 1'b1 && step !== 1'b1) begin
            check("wrap_without_step", {31'd0, step}, 32'd1);
        end
        if (step === 1'b1) begin
            step_cyc = cyc;
            check("step_width", {31'd0, prev_step}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_step", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("step_count", {16'd0, count_bcd}, {16'd0, e.cnt});
                check("step_wrap", {31'd0, wrap}, {31'd0, e.wr});
            end
        end
        prev_step = (step === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_val = RST_INT;
    endtask

    task automatic glitches(input int n);
        for (int i = 0; i < n; i++) begin
            btn_n = 1'b0;
            tick(int'($urandom_range(DEB - 1, 1)));
            btn_n = 1'b1;
            tick(int'($urandom_range(DEB - 1, 1)));
        end
    endtask

    task automatic press(input logic dir, input int hold, input int nbounce);
        up = dir;
        glitches(nbounce);
        model_press(dir);
        btn_n = 1'b0;
        tick(hold);
        btn_n = 1'b1;
        tick(int'(DEB) + 2 + int'($urandom_range(4, 0)));
        up = 1'($urandom_range(1, 0));
    endtask

    task automatic check_idle(input string name);
        check({name, "_count"}, {16'd0, count_bcd}, {16'd0, to_bcd(model_val)});
        check({name, "_pressed"}, {31'd0, pressed}, 32'd0);
    endtask

    initial begin
        int t0;

        do_reset();
        check("reset_count", {16'd0, count_bcd}, {16'd0, RST_VAL});
        check("reset_step", {31'd0, step}, 32'd0);
        check("reset_wrap", {31'd0, wrap}, 32'd0);
        check("reset_pressed", {31'd0, pressed}, 32'd0);

        // Clean press latency: step and pressed on the 6th edge after btn_n is first sampled low.
        up = 1'b1;
        btn_n = 1'b0;
        t0 = cyc;
        model_press(1'b1);
        tick(5);
        check("lat_early_pressed", {31'd0, pressed}, 32'd0);
        check("lat_early_count", {16'd0, count_bcd}, {16'd0, RST_VAL});
        tick(1);
        check("lat_step", {31'd0, step}, 32'd1);
        check("lat_pressed", {31'd0, pressed}, 32'd1);
        check("lat_count", {16'd0, count_bcd}, {16'd0, to_bcd(model_val)});
        tick(1);
        check("lat_step_cycle", 32'(step_cyc), 32'(t0 + 6));
        check("lat_step_drop", {31'd0, step}, 32'd0);
        tick(3);
        btn_n = 1'b1;
        tick(DEB + 2);
        check_idle("clean_press");

        // Bounce rejection: 2-cycle pulses, then runs one short of the debounce length.
        for (int i = 0; i < 3; i++) begin
            btn_n = 1'b0; tick(2); btn_n = 1'b1; tick(2);
        end
        tick(10);
        check_idle("bounce2");
        for (int i = 0; i < 3; i++) begin
            btn_n = 1'b0; tick(DEB - 1); btn_n = 1'b1; tick(DEB - 1);
        end
        tick(10);
        check_idle("bounce_short");

        // Wrap in both directions around 0000/9999.
        press(1'b1, DEB, 0);
        check_idle("wrap_up");
        press(1'b0, DEB + 1, 1);
        check_idle("wrap_down");
        press(1'b0, DEB + 2, 0);
        check_idle("borrow_no_wrap");
        press(1'b1, DEB, 0);
        press(1'b1, DEB, 2);
        check_idle("wrap_up2");

        // Long hold counts once.
        press(1'b1, 100, 0);
        check_idle("held_button");

        // Ripple carry through 0009->0010 and 0099->0100.
        for (int i = 0; i < 99; i++) begin
            press(1'b1, int'(DEB) + int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
        end
        check("carry_0100", {16'd0, count_bcd}, 32'h0000_0100);

        // clr on the accept edge: count reloads, no step, FSM still moves to held.
        up = 1'b1;
        btn_n = 1'b0;
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        model_val = RST_INT;
        check("clr_edge_count", {16'd0, count_bcd}, {16'd0, RST_VAL});
        check("clr_edge_step", {31'd0, step}, 32'd0);
        check("clr_edge_pressed", {31'd0, pressed}, 32'd1);
        tick(3);
        btn_n = 1'b1;
        tick(DEB + 2);
        check_idle("clr_release");

        // rst while held with the button still down requires a fresh qualification.
        up = 1'b1;
        model_press(1'b1);
        btn_n = 1'b0;
        tick(8);
        check("held_before_rst", {31'd0, pressed}, 32'd1);
        do_reset();
        check("rst_held_pressed", {31'd0, pressed}, 32'd0);
        check("rst_held_count", {16'd0, count_bcd}, {16'd0, RST_VAL});
        t0 = cyc;
        model_press(1'b1);
        tick(5);
        check("requal_early", {31'd0, pressed}, 32'd0);
        tick(1);
        check("requal_step", {31'd0, step}, 32'd1);
        check("requal_pressed", {31'd0, pressed}, 32'd1);
        tick(1);
        check("requal_cycle", 32'(step_cyc), 32'(t0 + 6));
        btn_n = 1'b1;
        tick(DEB + 2);
        check_idle("requal_release");

        // Random mix of presses, glitch bursts, clears and resets.
        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(9, 0));
            if (op <= 5) begin
                press(1'($urandom_range(1, 0)), int'(DEB) + int'($urandom_range(6, 0)),
                      int'($urandom_range(3, 0)));
            end else if (op == 6 || op == 7) begin
                glitches(int'($urandom_range(4, 1)));
                tick(DEB + 2);
            end else if (op == 8) begin
                clr = 1'b1;
                tick(1);
                clr = 1'b0;
                model_val = RST_INT;
            end else begin
                do_reset();
            end
            check_idle("rand");
        end

        tick(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
